rd_arb_x2_ram: RTL and testbench
================================

RD_ARB_X2_RAM -- requirements
Module: rd_arb_x2_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM read address width.
REQ-002 SHALL have parameter LEN_W, default 4, burst length field width; a burst is len+1 words.
REQ-003 SHALL have parameter RAM_LAT, default 2, fixed RAM read latency in cycles; legal range 1..8.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_i_0, req_i_1  input  1  burst read request from requester 0/1.
REQ-007 SHALL have ports addr_i_0, addr_i_1  input  ADDR_W  burst base address from requester 0/1.
REQ-008 SHALL have ports len_i_0, len_i_1  input  LEN_W  burst length minus one from requester 0/1.
REQ-009 SHALL have ports gnt_o_0, gnt_o_1  output  1  high for every cycle requester 0/1 owns the issue slot.
REQ-010 SHALL have ports rd_o_0, rd_o_1  output  1  read enable to RAM bank 0/1.
REQ-011 SHALL have port raddr_o  output  ADDR_W  shared read address to both banks.
REQ-012 SHALL have port ctrl_o  output  1  select for the 2:1 read-return crossbar (0 = bank 0, 1 = bank 1).
REQ-013 SHALL have ports done_o_0, done_o_1  output  1  one-cycle pulse when the last word of requester 0/1's burst reaches the crossbar.
REQ-014 SHALL have port busy_o  output  1  high while any burst is issuing or any read is in flight.

Function
REQ-015 SHALL implement FSM states IDLE and BURST.
REQ-016 IDLE: if any req_i_k high, SHALL pick a winner, latch its addr and len, and enter BURST next cycle; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single requester wins; both requesting -> the requester not served last wins; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-018 BURST: each cycle SHALL assert gnt_o_k and rd_o_k of the winner only, drive raddr_o = base + beat, beat = 0..len.
REQ-019 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-020 After beat len, SHALL return to IDLE; minimum gap between bursts = 1 IDLE cycle.
REQ-021 req_i_k deassertion or addr/len change during BURST SHALL be ignored; burst completes.
REQ-022 rd_o_0 and rd_o_1 SHALL never be high together; both low in IDLE; raddr_o holds last value in IDLE.
REQ-023 SHALL carry a RAM_LAT-stage pipeline of {valid, id, last} per issued read.
REQ-024 ctrl_o SHALL equal id at stage RAM_LAT when valid, and hold its previous value otherwise.
REQ-025 done_o_k SHALL pulse when stage RAM_LAT is valid, last, id = k.
REQ-026 First word of a burst granted in IDLE cycle T SHALL reach the crossbar at T+1+RAM_LAT.
REQ-027 busy_o SHALL be high when FSM = BURST or any pipeline stage valid.
REQ-028 Requester SHALL hold req until gnt; a request withdrawn before grant is lost without error.

Reset
REQ-029 rst_n_i low SHALL immediately force: FSM IDLE, pipeline invalid, gnt_o_*=0, rd_o_*=0, raddr_o=0, ctrl_o=0, done_o_*=0, busy_o=0, pointer=1.
REQ-030 Reset mid-burst SHALL abort the burst and drop in-flight reads; no done pulse produced.
REQ-031 After rst_n_i rises, first arbitration SHALL occur on the first rising edge with a request.

Verification (RAM_LAT=2)
REQ-032 req_i_0=1, addr 0x010, len 3 -> rd_o_0 four cycles, raddr 0x010..0x013, ctrl_o=0, done_o_0 one pulse 2 cycles after last rd.
REQ-033 Both requests held continuously, len 0 each -> grants alternate 0,1,0,1 with one IDLE cycle between; ctrl_o follows 2 cycles behind rd.
REQ-034 req_i_1, addr 0x3FE, len 3 -> raddr 0x3FE, 0x3FF, 0x000, 0x001.
REQ-035 req_i_0 dropped after cycle 1 of len-7 burst -> all 8 reads issued, done_o_0 pulses.
REQ-036 rst_n_i low at beat 2 of burst -> all outputs 0 same cycle, no done pulse; next request after release served normally.
REQ-037 Burst 0 then burst 1 back to back -> ctrl_o switches 0->1 exactly when bank-1 first word arrives, busy_o low only after final done.

Source files
------------

// File: rtl/rd_arb_x2_ram.sv
// rd_arb_x2_ram: two-requester round-robin burst-read arbiter in front of a
// two-bank RAM that shares one read address bus.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   req_i_k/addr_i_k/len_i_k burst request, base address, length-1 (k = 0,1)
//   gnt_o_k, rd_o_k         requester k owns the issue slot / bank k read enable
//   raddr_o                 shared read address (holds its value while idle)
//   ctrl_o                  read-return crossbar select (0 = bank 0, 1 = bank 1)
//   done_o_k                pulse when the last word of requester k's burst
//                           reaches the crossbar
//   busy_o                  a burst is issuing or a read is still in flight
module rd_arb_x2_ram #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i_0,
    input  logic              req_i_1,
    input  logic [ADDR_W-1:0] addr_i_0,
    input  logic [ADDR_W-1:0] addr_i_1,
    input  logic [LEN_W-1:0]  len_i_0,
    input  logic [LEN_W-1:0]  len_i_1,
    output logic              gnt_o_0,
    output logic              gnt_o_1,
    output logic              rd_o_0,
    output logic              rd_o_1,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              ctrl_o,
    output logic              done_o_0,
    output logic              done_o_1,
    output logic              busy_o
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic                owner;      // requester owning the current burst
    logic                ptr;        // last requester served
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat;
    logic [ADDR_W-1:0]   raddr_q;
    logic                any_req, win, last_beat, issue;

    // Read-return tracking, stage k holds the read issued k cycles ago.
    logic [RAM_LAT:1]    vld_pipe;
    logic [RAM_LAT:1]    id_pipe;
    logic [RAM_LAT:1]    last_pipe;
    logic                ctrl_q;

    assign any_req   = req_i_0 | req_i_1;
    // On a tie the requester not served last wins; otherwise the lone one.
    assign win       = (req_i_0 & req_i_1) ? ~ptr : req_i_1;
    assign last_beat = (beat == len_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        gnt_o_0   = 1'b0;
        gnt_o_1   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = BURST;
            end
            BURST: begin
                issue   = 1'b1;
                gnt_o_0 = ~owner;
                gnt_o_1 = owner;
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_o_0  = gnt_o_0;
    assign rd_o_1  = gnt_o_1;
    assign raddr_o = raddr_q;

    // Burst context is latched at grant; request inputs are ignored while
    // the burst runs. The address stops on the last beat so it holds in IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner   <= 1'b0;
            ptr     <= 1'b1;
            len_q   <= '0;
            beat    <= '0;
            raddr_q <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                owner   <= win;
                ptr     <= win;
                len_q   <= win ? len_i_1 : len_i_0;
                raddr_q <= win ? addr_i_1 : addr_i_0;
                beat    <= '0;
            end
        end else if (!last_beat) begin
            beat    <= beat + 1'b1;
            raddr_q <= raddr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe  <= '0;
            id_pipe   <= '0;
            last_pipe <= '0;
            ctrl_q    <= 1'b0;
        end else begin
            vld_pipe[1]  <= issue;
            id_pipe[1]   <= owner;
            last_pipe[1] <= last_beat;
            for (int k = 2; k <= int'(RAM_LAT); k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                id_pipe[k]   <= id_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
            end
            ctrl_q <= ctrl_o;
        end
    end

    // Crossbar follows the arriving word and otherwise keeps its last select.
    assign ctrl_o   = vld_pipe[RAM_LAT] ? id_pipe[RAM_LAT] : ctrl_q;
    assign done_o_0 = vld_pipe[RAM_LAT] & last_pipe[RAM_LAT] & ~id_pipe[RAM_LAT];
    assign done_o_1 = vld_pipe[RAM_LAT] & last_pipe[RAM_LAT] &  id_pipe[RAM_LAT];
    assign busy_o   = (state == BURST) | (|vld_pipe);

endmodule

// File: tb/tb_rd_arb_x2_ram.sv
module tb_rd_arb_x2_ram;

    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 4;
    localparam int RAM_LAT = 2;
    localparam int AMASK   = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [LEN_W-1:0]  len0 = '0, len1 = '0;
    logic              gnt0, gnt1, rd0, rd1, ctrl, done0, done1, busy;
    logic [ADDR_W-1:0] raddr;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    rd_arb_x2_ram #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RAM_LAT(RAM_LAT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_i_0(req0), .req_i_1(req1),
        .addr_i_0(addr0), .addr_i_1(addr1),
        .len_i_0(len0), .len_i_1(len1),
        .gnt_o_0(gnt0), .gnt_o_1(gnt1),
        .rd_o_0(rd0), .rd_o_1(rd1),
        .raddr_o(raddr), .ctrl_o(ctrl),
        .done_o_0(done0), .done_o_1(done1),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Reference model: the current burst as (owner, base, len, beat) and the
    // word arrivals at the crossbar as a time-stamped queue.
    typedef struct {int t; bit id; bit last;} arr_t;
    arr_t q[$];
    bit   m_act, m_own, m_ptr, m_ctrl;
    int   m_base, m_len, m_beat, m_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_act = 0; m_own = 0; m_ptr = 1; m_ctrl = 0;
        m_base = 0; m_len = 0; m_beat = 0; m_hold = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt0"}, 32'(gnt0), 0);
        check({tag, ".gnt1"}, 32'(gnt1), 0);
        check({tag, ".rd0"},  32'(rd0), 0);
        check({tag, ".rd1"},  32'(rd1), 0);
        check({tag, ".raddr"}, 32'(raddr), 0);
        check({tag, ".ctrl"}, 32'(ctrl), 0);
        check({tag, ".done0"}, 32'(done0), 0);
        check({tag, ".done1"}, 32'(done1), 0);
        check({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic set_in(input bit r0, input bit r1, input int a0, input int a1,
                          input int l0, input int l1);
        req0 = r0; req1 = r1;
        addr0 = ADDR_W'(a0); addr1 = ADDR_W'(a1);
        len0 = LEN_W'(l0); len1 = LEN_W'(l1);
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model.
    task automatic cycle();
        bit a_v, a_id, a_last, pend, e_ctrl;
        int e_addr;
        a_v = 0; a_id = 0; a_last = 0; pend = 0;
        @(negedge clk);
        foreach (q[i]) begin
            if (q[i].t == cyc) begin a_v = 1; a_id = q[i].id; a_last = q[i].last; end
            if (q[i].t >= cyc) pend = 1;
        end
        e_addr = m_act ? ((m_base + m_beat) & AMASK) : m_hold;
        e_ctrl = a_v ? a_id : m_ctrl;
        check("gnt0",  32'(gnt0),  32'(m_act && !m_own));
        check("gnt1",  32'(gnt1),  32'(m_act && m_own));
        check("rd0",   32'(rd0),   32'(m_act && !m_own));
        check("rd1",   32'(rd1),   32'(m_act && m_own));
        check("raddr", 32'(raddr), 32'(e_addr));
        check("ctrl",  32'(ctrl),  32'(e_ctrl));
        check("done0", 32'(done0), 32'(a_v && a_last && !a_id));
        check("done1", 32'(done1), 32'(a_v && a_last && a_id));
        check("busy",  32'(busy),  32'(m_act || pend));
        m_ctrl = e_ctrl;
        if (m_act) m_hold = e_addr;
        while (q.size() > 0 && q[0].t <= cyc) void'(q.pop_front());
        if (m_act) begin
            q.push_back('{cyc + RAM_LAT, m_own, m_beat == m_len});
            if (m_beat == m_len) m_act = 0;
            else m_beat++;
        end else if (req0 || req1) begin
            if (req0 && req1) m_own = ~m_ptr;
            else              m_own = req1;
            m_ptr  = m_own;
            m_act  = 1;
            m_base = m_own ? int'(addr1) : int'(addr0);
            m_len  = m_own ? int'(len1) : int'(len0);
            m_beat = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called just after a rising edge: reset must clear outputs at once.
    task automatic do_reset(input string tag);
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check_all_zero(tag);
        model_reset();
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc += 2;
    endtask

    initial begin
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single burst from requester 0.
        set_in(1, 0, 'h010, 0, 3, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        cycles(8);

        // Both held with len 0: alternate grants.
        set_in(1, 1, 'h020, 'h220, 0, 0);
        cycles(10);
        set_in(0, 0, 0, 0, 0, 0);
        cycles(4);

        // Address wrap.
        set_in(0, 1, 0, 'h3FE, 0, 3);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        cycles(8);

        // Request dropped and inputs changed mid-burst.
        set_in(1, 0, 'h100, 0, 7, 0);
        cycle();
        cycle();
        set_in(0, 0, 'h155, 'h2AA, 2, 5);
        cycles(12);

        // Reset at beat 2.
        set_in(1, 0, 'h040, 0, 5, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        cycles(2);
        do_reset("midburst");
        cycles(3);
        set_in(1, 0, 'h080, 0, 1, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        cycles(6);

        // Back-to-back bursts 0 then 1.
        set_in(1, 0, 'h200, 0, 2, 0);
        cycle();
        set_in(0, 1, 0, 'h300, 0, 2);
        cycle();
        cycles(3);
        set_in(0, 0, 0, 0, 0, 0);
        cycles(8);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            set_in(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                   int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
            else cycle();
        end
        set_in(0, 0, 0, 0, 0, 0);
        cycles(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
